adder_result_fifo: RTL and testbench
====================================

# adder_result_fifo

Downstream capture stage for the registered wide adder (`stormbreaker_delay`, fixed 2-cycle latency). It tracks which adder cycles carry real operands, captures the matching `sum`/`cout` into a small FIFO, and presents them on a valid/ready output. It also returns a credit-style `in_ready` to the operand source, so issued results never overflow the FIFO.

## Interface
- `W`, 128, operand/sum width; must match the adder.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `LAT`, 2, adder latency in cycles from operand presentation to registered `sum`; ≥1.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: high in the cycle the operand source drives real `a`/`b`/`cin` into the adder.
- `in_ready` output 1: high when a result issued this cycle is guaranteed a FIFO slot.
- `sum` input W: registered adder sum.
- `cout` input 1: registered adder carry-out.
- `out_valid` output 1: FIFO head is valid.
- `out_ready` input 1: consumer accepts the head.
- `out_sum` output W: head sum.
- `out_cout` output 1: head carry.
- `count` output $clog2(DEPTH+1): current FIFO occupancy.
- `overflow` output 1: sticky flag; a result arrived while the FIFO was full and was dropped.

## Operation
- **Tag pipeline.** A LAT-stage shift register `vpipe` shifts `in_valid` in every cycle, regardless of `in_ready`. Stage LAT-1 (`arrive`) is high exactly in the cycle the corresponding `sum`/`cout` are stable on the inputs.
- **Push.** On `arrive`, push `{cout, sum}` at the clock edge ending that cycle.
- **Pop.** Occurs when `out_valid & out_ready`. The head advances at the same edge.
- **In-flight count.** `inflight` = popcount of `vpipe`.
- **Credit.** `in_ready = (count + inflight) < DEPTH`. This is combinational from registers only, with no path from `in_valid` or `out_ready`.
- **Full with a pop.** When `arrive` occurs with the FIFO full and a pop in the same cycle, the push is accepted and `count` is unchanged.
- **Full without a pop.** When `arrive` occurs with the FIFO full and no pop, the result is dropped and `overflow` is set. `overflow` stays set until reset.
- **Empty.** With the FIFO empty, `out_valid=0`; `out_sum`/`out_cout` hold the last popped values, or 0 after reset.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap naturally. `count` is tracked separately, so full and empty are unambiguous.
- **Storage.** Storage is W+1 bits per entry; there is no arithmetic on the data.

## Timing
- **Reset values.** `vpipe=0`, `count=0`, pointers 0, `out_valid=0`, `out_sum=0`, `out_cout=0`, `overflow=0`, `in_ready=1`.
- **Result path.** With `in_valid` high in cycle t, `arrive` is high in cycle t+LAT. The push occurs at the end of t+LAT, and `out_valid` rises in t+LAT+1.
- **Throughput.** One push and one pop per cycle are sustained indefinitely when `out_ready` is held high.
- **Pop timing.** A pop in cycle k lowers `count` from cycle k+1. `in_ready` reflects the freed slot from k+1.
- **Reset during operation.** Asserting `rst_n` low clears `vpipe` and the FIFO immediately. Results still inside the adder's own (unreset) registers are discarded because their tags are gone.
- **Reset release.** The first valid issue is allowed in the first cycle after `rst_n` rises.

## Configuration
- **Macro:** `ADDER_RESULT_FIFO_CARRY_STATS_EN`.
- **Defined.**
  - Adds an output `carry_count` [15:0], reset to 0.
  - It increments at each accepted push whose `cout=1`. Dropped results do not count.
  - It saturates at 16'hFFFF.
- **Undefined.** The port and counter are absent; all other behaviour is identical.

## Test plan
- **Single result.** After reset, pulse `in_valid` in cycle 5 with adder a=1, b=2^128−1, cin=0, and hold `out_ready=1`. Required: `out_valid` only in cycle 8 with `out_sum=0`, `out_cout=1`; `count` returns to 0.
- **Credit fill.** Hold `out_ready=0` and `in_valid=1` every cycle that `in_ready=1`. Required: exactly 4 issues, `in_ready` low from the cycle after the 4th issue, `count` reaches 4, `overflow=0`.
- **Forced overflow.** Hold `out_ready=0` and `in_valid=1` continuously, ignoring `in_ready`, for 6 cycles. Required: `count=4`, `overflow=1`, and draining yields the first 4 sums in issue order.
- **Streaming and wrap.** Issue 20 back-to-back operations with a=i, b=i, cin=1, and hold `out_ready=1`. Required: outputs 2i+1 in order on 20 consecutive cycles, with pointers wrapping 5 times.
- **Full with simultaneous push and pop.** With `count=4`, an arriving result and `out_ready=1` in the same cycle. Required: `count` stays 4, no overflow, and the new entry is at the tail.
- **Reset during operation.** Assert `rst_n` low for 1 cycle with 2 results in flight and 3 stored. Required: all outputs return to reset values, no stale `out_valid` afterwards, and `carry_count` (if enabled) is 0.

Source files
------------

// File: rtl/adder_result_fifo.sv
// Capture FIFO behind the fixed-latency wide adder: tags issued operands, stores the
// matching sum/cout, and returns credit. Optional carry statistics: ADDER_RESULT_FIFO_CARRY_STATS_EN.
module adder_result_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 sum,
    input  logic                         cout,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [W-1:0]                 out_sum,
    output logic                         out_cout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
`ifdef ADDER_RESULT_FIFO_CARRY_STATS_EN
    ,
    output logic [15:0]                  carry_count
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(LAT + 1);
    localparam int SW = CW + IW;

    logic [LAT-1:0] vpipe_q, vpipe_d;
    logic [W:0]     mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [W:0]     last_q;
    logic           overflow_q;

    logic           arrive, full, pop, push, drop;
    logic [IW-1:0]  inflight;
    logic [SW-1:0]  occupancy;
    logic [W:0]     head;

    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = in_valid;
        for (int i = 1; i < LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
    end

    // Every tag still in the adder already owns a slot, so credit counts them too.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + IW'(vpipe_q[i]);
        end
    end

    assign occupancy = SW'(count_q) + SW'(inflight);
    assign in_ready  = occupancy < SW'(DEPTH);

    assign arrive  = vpipe_q[LAT-1];
    assign full    = (count_q == CW'(DEPTH));
    assign pop     = (count_q != '0) && out_ready;
    assign push    = arrive && (!full || pop);
    assign drop    = arrive && full && !pop;
    assign count_d = count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            vpipe_q <= vpipe_d;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: it is only observed through count-qualified reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cout, sum};
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_sum   = out_valid ? head[W-1:0] : last_q[W-1:0];
    assign out_cout  = out_valid ? head[W]     : last_q[W];
    assign count     = count_q;
    assign overflow  = overflow_q;

`ifdef ADDER_RESULT_FIFO_CARRY_STATS_EN
    logic [15:0] carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= '0;
        end else if (push && cout && (carry_q != 16'hFFFF)) begin
            carry_q <= carry_q + 16'd1;
        end
    end

    assign carry_count = carry_q;
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Directed bench for adder_result_fifo with a behavioural 2-cycle registered adder in front.
module tb_adder_result_fifo;

    localparam int W = 128;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   sum;
    logic           cout;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_sum;
    logic           out_cout;
    logic [2:0]     count;
    logic           overflow;
`ifdef ADDER_RESULT_FIFO_CARRY_STATS_EN
    logic [15:0]    carry_count;
`endif

    logic [W-1:0]   a_drv = '0;
    logic [W-1:0]   b_drv = '0;
    logic           cin_drv = 1'b0;
    logic [W:0]     s1_q, s2_q;

    int checks = 0;
    int errors = 0;

    adder_result_fifo #(.W(W), .DEPTH(4), .LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .count     (count),
        .overflow  (overflow)
`ifdef ADDER_RESULT_FIFO_CARRY_STATS_EN
        ,
        .carry_count (carry_count)
`endif
    );

    always #5 clk = ~clk;

    // Unreset two-stage adder: operands of cycle t appear on sum/cout in cycle t+2.
    always @(posedge clk) begin
        s1_q <= {1'b0, a_drv} + {1'b0, b_drv} + {{W{1'b0}}, cin_drv};
        s2_q <= s1_q;
    end
    assign sum  = s2_q[W-1:0];
    assign cout = s2_q[W];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
        checks++; if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %0h exp 0", out_sum); end
        checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %0b exp 0", out_cout); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b exp 0", overflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        repeat (4) tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_drv     = 128'd1;
        b_drv     = '1;
        cin_drv   = 1'b0;
        tick();
        in_valid = 1'b0;
        a_drv    = '0;
        b_drv    = '0;
        for (int k = 1; k <= 4; k++) begin
            if (k == 3) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid_t3: got %0b exp 1", out_valid); end
                checks++; if (out_sum !== '0 || out_cout !== 1'b1) begin errors++; $display("FAIL single_data: got sum %0h cout %0b exp sum 0 cout 1", out_sum, out_cout); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_t%0d: got %0b exp 0", k, out_valid); end
            end
            tick();
        end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_end: got %0d exp 0", count); end
        out_ready = 1'b0;
    endtask

    task automatic test_credit_fill();
        int issues;
        int last_c;
        do_reset();
        issues = 0;
        last_c = -10;
        for (int c = 0; c < 12; c++) begin
            if (issues == 4 && c == last_c + 1) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL credit_ready_after_4th: got %0b exp 0", in_ready); end
            end
            in_valid = in_ready;
            a_drv    = W'(100 + issues);
            b_drv    = '0;
            cin_drv  = 1'b0;
            if (in_ready) begin
                issues++;
                if (issues == 4) last_c = c;
            end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (issues !== 4) begin errors++; $display("FAIL credit_issues: got %0d exp 4", issues); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL credit_count: got %0d exp 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL credit_overflow: got %0b exp 0", overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL credit_ready_full: got %0b exp 0", in_ready); end
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            checks++; if (out_valid !== 1'b1 || out_sum !== W'(100 + k)) begin errors++; $display("FAIL credit_drain_%0d: got valid %0b sum %0d exp valid 1 sum %0d", k, out_valid, out_sum, 100 + k); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL credit_empty: got valid %0b count %0d exp 0 0", out_valid, count); end
        checks++; if (out_sum !== W'(103)) begin errors++; $display("FAIL credit_hold_last: got %0d exp 103", out_sum); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL credit_ready_empty: got %0b exp 1", in_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            a_drv    = W'(200 + c);
            b_drv    = '0;
            cin_drv  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d exp 4", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b exp 1", overflow); end
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            checks++; if (out_valid !== 1'b1 || out_sum !== W'(200 + k)) begin errors++; $display("FAIL ovf_drain_%0d: got valid %0b sum %0d exp valid 1 sum %0d", k, out_valid, out_sum, 200 + k); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got count %0d ovf %0b exp 0 1", count, overflow); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            in_valid = (c < 20);
            a_drv    = W'(c);
            b_drv    = W'(c);
            cin_drv  = 1'b1;
            if (c >= 3 && c < 23) begin
                checks++; if (out_valid !== 1'b1 || out_sum !== W'(2 * (c - 3) + 1)) begin errors++; $display("FAIL stream_%0d: got valid %0b sum %0d exp valid 1 sum %0d", c - 3, out_valid, out_sum, 2 * (c - 3) + 1); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle_c%0d: got %0b exp 0", c, out_valid); end
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL stream_end: got count %0d ovf %0b exp 0 0", count, overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int c = 0; c < 7; c++) begin
            in_valid  = (c < 5);
            a_drv     = W'(300 + c);
            b_drv     = '0;
            cin_drv   = 1'b0;
            out_ready = (c == 6);
            if (c == 6) begin
                checks++; if (count !== 3'd4 || out_sum !== W'(300)) begin errors++; $display("FAIL fpp_before: got count %0d sum %0d exp 4 300", count, out_sum); end
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fpp_count: got %0d exp 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_overflow: got %0b exp 0", overflow); end
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            checks++; if (out_valid !== 1'b1 || out_sum !== W'(301 + k)) begin errors++; $display("FAIL fpp_drain_%0d: got valid %0b sum %0d exp valid 1 sum %0d", k, out_valid, out_sum, 301 + k); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            a_drv    = '1;
            b_drv    = 128'd1;
            cin_drv  = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL rmid_count_before: got %0d exp 3", count); end
`ifdef ADDER_RESULT_FIFO_CARRY_STATS_EN
        checks++; if (carry_count !== 16'd3) begin errors++; $display("FAIL rmid_carry_before: got %0d exp 3", carry_count); end
`endif
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rmid_async: got valid %0b count %0d ready %0b exp 0 0 1", out_valid, count, in_ready); end
        checks++; if (out_sum !== '0 || out_cout !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rmid_data: got sum %0h cout %0b ovf %0b exp 0 0 0", out_sum, out_cout, overflow); end
`ifdef ADDER_RESULT_FIFO_CARRY_STATS_EN
        checks++; if (carry_count !== 16'd0) begin errors++; $display("FAIL rmid_carry_after: got %0d exp 0", carry_count); end
`endif
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL rmid_stale_%0d: got valid %0b count %0d exp 0 0", k, out_valid, count); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_credit_fill();
        test_overflow();
        test_stream();
        test_full_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
